branch_predictor: RTL and testbench

Fetch-side branch predictor that receives branch and jump resolution updates from the execute (AGEX) stage. It returns a next-PC prediction to the fetch stage for every fetch PC, using a direct-mapped BTB and a gshare pattern history table of 2-bit counters. Only the update port is sequential; prediction is a combinational read of state held in flops. The block also keeps committed-branch accuracy counters.

---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB plus 2-bit PHT next-PC predictor with resolution updates
// Define BP_GSHARE_EN for gshare (pc ^ history) indexing; otherwise bimodal with the BHR held at zero.
module branch_predictor #(
   parameter int DBITS        = 32,
   parameter int BTB_IDX_BITS = 4,
   parameter int BHR_BITS     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] fetch_pc,
   output logic [DBITS-1:0] pred_next_pc,
   output logic             pred_taken,
   input  logic             upd_valid,
   input  logic [DBITS-1:0] upd_pc,
   input  logic [DBITS-1:0] upd_target,
   input  logic             upd_is_br,
   input  logic             upd_is_jmp,
   input  logic             upd_taken,
   input  logic             upd_mispred,
   output logic [31:0]      total_branches,
   output logic [31:0]      correct_predictions
);
   localparam int TAG_BITS = DBITS - 2 - BTB_IDX_BITS;
   localparam int BTB_N    = 1 << BTB_IDX_BITS;
   localparam int PHT_N    = 1 << BHR_BITS;

   logic [BTB_N-1:0]        btb_valid_q;
   logic [BTB_N-1:0]        btb_jmp_q;
   logic [TAG_BITS-1:0]     btb_tag_q [BTB_N];
   logic [DBITS-1:0]        btb_tgt_q [BTB_N];
   logic [1:0]              pht_q [PHT_N];
   logic [BHR_BITS-1:0]     bhr_q, bhr_d;
   logic [1:0]              pht_d, u_ctr;
   logic [31:0]             total_q, total_d;
   logic [31:0]             correct_q, correct_d;

   logic [BTB_IDX_BITS-1:0] f_idx, u_idx;
   logic [TAG_BITS-1:0]     f_tag, u_tag;
   logic [BHR_BITS-1:0]     f_pidx, u_pidx;
   logic                    f_hit, upd_fire;
   logic                    unused_upd_pc_lsbs;

   assign f_idx  = fetch_pc[BTB_IDX_BITS+1:2];
   assign f_tag  = fetch_pc[DBITS-1:BTB_IDX_BITS+2];
   assign f_pidx = fetch_pc[BHR_BITS+1:2] ^ bhr_q;
   assign u_idx  = upd_pc[BTB_IDX_BITS+1:2];
   assign u_tag  = upd_pc[DBITS-1:BTB_IDX_BITS+2];
   assign u_pidx = upd_pc[BHR_BITS+1:2] ^ bhr_q;
   assign unused_upd_pc_lsbs = ^upd_pc[1:0];

   assign upd_fire = upd_valid && (upd_is_br || upd_is_jmp);

   // Prediction reads only flopped state, so a same-cycle update is seen next cycle.
   assign f_hit        = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
   assign pred_taken   = f_hit && (btb_jmp_q[f_idx] || pht_q[f_pidx][1]);
   assign pred_next_pc = pred_taken ? btb_tgt_q[f_idx] : fetch_pc + DBITS'(4);

   assign total_branches      = total_q;
   assign correct_predictions = correct_q;

   always_comb begin
      u_ctr = pht_q[u_pidx];
      pht_d = u_ctr;
      if (upd_taken && (u_ctr != 2'b11))
         pht_d = u_ctr + 2'b01;
      else if (!upd_taken && (u_ctr != 2'b00))
         pht_d = u_ctr - 2'b01;
      bhr_d = bhr_q;
`ifdef BP_GSHARE_EN
      if (upd_is_br)
         bhr_d = {bhr_q[BHR_BITS-2:0], upd_taken};
`endif
      total_d   = total_q + 32'd1;
      correct_d = upd_mispred ? correct_q : correct_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btb_valid_q <= '0;
         for (int i = 0; i < PHT_N; i++)
            pht_q[i] <= 2'b01;
         bhr_q     <= '0;
         total_q   <= '0;
         correct_q <= '0;
      end else if (upd_fire) begin
         if (upd_taken)
            btb_valid_q[u_idx] <= 1'b1;
         if (upd_is_br) begin
            pht_q[u_pidx] <= pht_d;
            bhr_q         <= bhr_d;
         end
         total_q   <= total_d;
         correct_q <= correct_d;
      end
   end

   // Payload fields are qualified by the valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      if (!reset && upd_fire && upd_taken) begin
         btb_tag_q[u_idx] <= u_tag;
         btb_tgt_q[u_idx] <= upd_target;
         btb_jmp_q[u_idx] <= upd_is_jmp;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && upd_valid)
         assert (!(upd_is_br && upd_is_jmp));
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
// Reference model tracks BTB/PHT/BHR/counters; directed checks follow the test plan for either build.
module tb_branch_predictor;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fetch_pc;
   logic [31:0] pred_next_pc;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_is_br;
   logic        upd_is_jmp;
   logic        upd_taken;
   logic        upd_mispred;
   logic [31:0] total_branches;
   logic [31:0] correct_predictions;

   int n_checks = 0;
   int n_err    = 0;

   logic        m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   logic        m_jmp   [16];
   logic [1:0]  m_pht   [256];
   logic [7:0]  m_bhr;
   logic [31:0] m_total;
   logic [31:0] m_correct;

   logic [32:0] q_pred [$];
   logic [63:0] q_cnt  [$];

   branch_predictor dut (
      .clk                 (clk),
      .reset               (reset),
      .fetch_pc            (fetch_pc),
      .pred_next_pc        (pred_next_pc),
      .pred_taken          (pred_taken),
      .upd_valid           (upd_valid),
      .upd_pc              (upd_pc),
      .upd_target          (upd_target),
      .upd_is_br           (upd_is_br),
      .upd_is_jmp          (upd_is_jmp),
      .upd_taken           (upd_taken),
      .upd_mispred         (upd_mispred),
      .total_branches      (total_branches),
      .correct_predictions (correct_predictions)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
      m_bhr     = 8'h00;
      m_total   = 32'd0;
      m_correct = 32'd0;
   endtask

   task automatic model_pred(input logic [31:0] pc, output logic tk, output logic [31:0] nxt);
      logic [3:0] bi;
      logic [7:0] pi;
      bi  = pc[5:2];
      pi  = pc[9:2] ^ m_bhr;
      tk  = m_valid[bi] && (m_tag[bi] == pc[31:6]) && (m_jmp[bi] || m_pht[pi][1]);
      nxt = tk ? m_tgt[bi] : pc + 32'd4;
   endtask

   task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt,
                               input logic br, input logic jmp, input logic tk, input logic mp);
      logic [3:0] bi;
      logic [7:0] pi;
      bi = pc[5:2];
      pi = pc[9:2] ^ m_bhr;
      if (tk) begin
         m_valid[bi] = 1'b1;
         m_tag[bi]   = pc[31:6];
         m_tgt[bi]   = tgt;
         m_jmp[bi]   = jmp;
      end
      if (br) begin
         if (tk && m_pht[pi] != 2'b11) m_pht[pi] = m_pht[pi] + 2'b01;
         else if (!tk && m_pht[pi] != 2'b00) m_pht[pi] = m_pht[pi] - 2'b01;
`ifdef BP_GSHARE_EN
         m_bhr = {m_bhr[6:0], tk};
`endif
      end
      m_total = m_total + 32'd1;
      if (!mp) m_correct = m_correct + 32'd1;
   endtask

   // One clock: drive at negedge, check prediction before the edge, check counters after it.
   task automatic cycle(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                        input logic [31:0] utgt, input logic br, input logic jmp,
                        input logic tk, input logic mp, input logic rst,
                        input bit dchk, input logic [31:0] dnext, input string tag);
      logic        etk;
      logic [32:0] ep;
      logic [63:0] ec;
      logic [31:0] enx;
      @(negedge clk);
      fetch_pc    = fpc;
      upd_valid   = uv;
      upd_pc      = upc;
      upd_target  = utgt;
      upd_is_br   = br;
      upd_is_jmp  = jmp;
      upd_taken   = tk;
      upd_mispred = mp;
      reset       = rst;
      model_pred(fpc, etk, enx);
      q_pred.push_back({etk, enx});
      #1;
      ep = q_pred.pop_front();
      check({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, ep[32]});
      check({tag, "_pred_next_pc"}, pred_next_pc, ep[31:0]);
      if (dchk) check({tag, "_directed_next_pc"}, pred_next_pc, dnext);
      @(posedge clk);
      if (rst) model_reset();
      else if (uv && (br || jmp)) model_update(upc, utgt, br, jmp, tk, mp);
      q_cnt.push_back({m_total, m_correct});
      #1;
      ec = q_cnt.pop_front();
      check({tag, "_total_branches"}, total_branches, ec[63:32]);
      check({tag, "_correct_predictions"}, correct_predictions, ec[31:0]);
   endtask

   task automatic fetch(input logic [31:0] fpc, input logic [31:0] dnext, input string tag);
      cycle(fpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dnext, tag);
   endtask

   task automatic upd(input logic [31:0] upc, input logic [31:0] utgt, input logic br,
                      input logic jmp, input logic tk, input logic mp, input string tag);
      cycle(32'h0, 1'b1, upc, utgt, br, jmp, tk, mp, 1'b0, 1'b0, 32'h0, tag);
   endtask

   initial begin
      logic [31:0] rpc, rfpc;
      logic        rjmp, rtk;

      reset = 1'b1; fetch_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
      upd_is_br = 1'b0; upd_is_jmp = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();

      fetch(32'h100, 32'h104, "t1_reset");
      check("t1_total_zero", total_branches, 32'd0);

      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, "t2_upd");
`ifdef BP_GSHARE_EN
      fetch(32'h100, 32'h104, "t2_hist_xor");
`else
      fetch(32'h100, 32'h80, "t2_bimodal");
`endif

      upd(32'h200, 32'h400, 1'b0, 1'b1, 1'b1, 1'b1, "t3_upd");
      fetch(32'h200, 32'h400, "t3_jmp_hit");
      fetch(32'h240, 32'h244, "t3_tag_miss");
      fetch(32'h100, 32'h104, "t3_alias_evicted");

      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, "t4_tk0");
      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, "t4_tk1");
`ifndef BP_GSHARE_EN
      fetch(32'h100, 32'h80, "t4_sat_hi");
`endif
      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, "t4_nt0");
      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, "t4_nt1");
      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, "t4_nt2");
`ifndef BP_GSHARE_EN
      fetch(32'h100, 32'h104, "t4_sat_lo");
`endif
      upd(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, "t4_tk_after_lo");
`ifndef BP_GSHARE_EN
      fetch(32'h100, 32'h104, "t4_no_wrap");
`endif

      cycle(32'h300, 1'b1, 32'h300, 32'h500, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
            1'b1, 32'h304, "t5_same_cycle");
      fetch(32'h300, 32'h500, "t5_next_cycle");

      cycle(32'h0, 1'b1, 32'h380, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
            1'b0, 32'h0, "t_ignored_upd");
      fetch(32'h380, 32'h384, "t_ignored_fetch");

      for (int i = 0; i < 40; i++) begin
         rpc  = 32'($urandom_range(0, 127)) << 3;
         rfpc = $urandom_range(0, 1) ? rpc : 32'($urandom_range(0, 127)) << 3;
         rjmp = 1'($urandom_range(0, 1));
         rtk  = rjmp ? 1'b1 : 1'($urandom_range(0, 1));
         cycle(rfpc, 1'($urandom_range(0, 3) != 0), rpc, 32'($urandom) & 32'hFFFF_FFFC,
               !rjmp, rjmp, rtk, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0, "rand");
      end

      upd(32'h300, 32'h500, 1'b0, 1'b1, 1'b1, 1'b0, "t6_prep");
      cycle(32'h300, 1'b1, 32'h340, 32'h900, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
            1'b1, 32'h500, "t6_reset_upd");
      reset = 1'b0;
      fetch(32'h300, 32'h304, "t6_no_hit");
      fetch(32'h340, 32'h344, "t6_upd_dropped");
      check("t6_total_zero", total_branches, 32'd0);
      check("t6_correct_zero", correct_predictions, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
